fwd_hazard_ctrl: RTL and testbench

Generates the forwarding-select codes for the 3-input operand multiplexers in front of the ALU, and the pipeline stall/bubble controls that keep them valid.
- Tracks destination registers of in-flight instructions in EX, MEM and WB.
- Detects load-use and multiply/divide (HI/LO) hazards.
- Sits between decode (ID) and the EX-stage operand muxes.
- Select outputs are registered, so they are stable for the whole EX cycle of the consuming instruction.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 36 +++
 rtl/fwd_hazard_ctrl_if.sv | 46 ++++
 rtl/fwd_hazard_ctrl_fwd_match.sv | 48 ++++
 rtl/fwd_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl_pkg
// Brief  : Shared types for the forwarding / hazard controller.
//          Holds the select encodings, the register-address width and the
//          pipeline slot record.
//          Optional feature macro: WB_BYPASS_EN (enables select code 3).
// Rev    : 1.0  initial release
// ============================================================================
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_WB    = 2'd3;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t dest;
    logic      wr_en;
    logic      is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // Register 0 is hard-wired, so a write to it is never a producer.
  function automatic logic slot_writes(slot_t s, reg_addr_t r);
    return s.valid && s.wr_en && (s.dest == r) && (r != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl_if
// Brief  : Decode-side bundle into the forwarding / hazard controller and
//          the controls it returns to the pipeline.
//          Optional feature macro: WB_BYPASS_EN (affects select encoding only).
// Rev    : 1.0  initial release
// ============================================================================
interface fwd_hazard_ctrl_if
  import fwd_hazard_ctrl_pkg::*;
();

  logic      id_valid;
  reg_addr_t id_rs;
  reg_addr_t id_rt;
  logic      id_rs_use;
  logic      id_rt_use;
  reg_addr_t id_rd;
  logic      id_wr_en;
  logic      id_is_load;
  logic      id_is_muldiv;
  logic      id_reads_hilo;
  logic      flush;

  logic       stall_o;
  logic       ex_bubble;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       muldiv_busy;

  // Decode side: presents the ID instruction, consumes stall/select controls.
  modport master (
    output id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_rd, id_wr_en,
           id_is_load, id_is_muldiv, id_reads_hilo, flush,
    input  stall_o, ex_bubble, fwd_a_sel, fwd_b_sel, muldiv_busy
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_rd, id_wr_en,
           id_is_load, id_is_muldiv, id_reads_hilo, flush,
    output stall_o, ex_bubble, fwd_a_sel, fwd_b_sel, muldiv_busy
  );

endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
`default_nettype none
// ============================================================================
// Module : fwd_match
// Brief  : Combinational source-operand comparator. Returns the forwarding
//          select for one operand given the in-flight EX/MEM/WB slots.
//          Youngest producer wins.
//          Optional feature macro: WB_BYPASS_EN (adds WB-stage code 3).
// Rev    : 1.0  initial release
// ============================================================================
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  reg_addr_t  src,
  input  logic       use_src,
  input  slot_t      ex_slot,
  input  slot_t      mem_slot,
  input  slot_t      wb_slot,
  output logic [1:0] sel
);

  // Priority compare, youngest in-flight producer first.
  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (slot_writes(ex_slot, src)) begin
        sel = FWD_EXMEM;
      end else if (slot_writes(mem_slot, src)) begin
        sel = FWD_MEMWB;
      end
`ifdef WB_BYPASS_EN
      else if (slot_writes(wb_slot, src)) begin
        sel = FWD_WB;
      end
`endif
    end
  end

  // Load flags are only relevant to stall detection, not to selection; without
  // the WB bypass the register file's write-before-read covers the WB stage.
  logic unused_bits;
`ifdef WB_BYPASS_EN
  assign unused_bits = ex_slot.is_load ^ mem_slot.is_load ^ wb_slot.is_load;
`else
  assign unused_bits = ^{ex_slot.is_load, mem_slot.is_load, wb_slot};
`endif

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl
// Brief  : Forwarding-select and stall/bubble controller for the EX operand
//          muxes. Tracks EX/MEM/WB destinations, detects load-use and HI/LO
//          hazards, and registers the select codes on the EX advance.
//          Register width comes from fwd_hazard_ctrl_pkg::REG_AW.
//          Optional feature macro: WB_BYPASS_EN (WB-stage select code 3).
// Rev    : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_ctrl_if.slave   bus
);

  slot_t            ex_q,  ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic             ex_bubble_q, ex_bubble_d;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_use;
  logic       hilo_haz;
  logic       stall;
  logic       advance;

  fwd_match u_match_a (
    .src      (bus.id_rs),
    .use_src  (bus.id_rs_use),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (sel_a)
  );

  fwd_match u_match_b (
    .src      (bus.id_rt),
    .use_src  (bus.id_rt_use),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (sel_b)
  );

  // Hazard detection for the ID instruction; a squash overrides any stall.
  always_comb begin
    load_use = ex_q.is_load &&
               ((bus.id_rs_use && slot_writes(ex_q, bus.id_rs)) ||
                (bus.id_rt_use && slot_writes(ex_q, bus.id_rt)));
    hilo_haz = (bus.id_is_muldiv || bus.id_reads_hilo) && (cnt_q != '0);
    stall    = bus.id_valid && !bus.flush && (load_use || hilo_haz);
    advance  = bus.id_valid && !bus.flush && !stall;
  end

  // Next-state: shift the slots, admit ID or a bubble, update the busy count.
  always_comb begin
    ex_d        = SLOT_EMPTY;
    mem_d       = ex_q;
    wb_d        = mem_q;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    ex_bubble_d = 1'b1;
    cnt_d       = cnt_q;

    if (advance) begin
      ex_d.valid   = 1'b1;
      ex_d.dest    = bus.id_rd;
      ex_d.wr_en   = bus.id_wr_en;
      ex_d.is_load = bus.id_is_load;
      fwd_a_d      = sel_a;
      fwd_b_d      = sel_b;
      ex_bubble_d  = 1'b0;
    end

    // A flushed or stalled ID mul/div never reaches EX, so it cannot reload
    // the counter; an already-running one keeps counting through a flush.
    if (advance && bus.id_is_muldiv) begin
      cnt_d = CNT_W'(MULDIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pipeline state and registered controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      cnt_q       <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      ex_bubble_q <= 1'b1;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      cnt_q       <= cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      ex_bubble_q <= ex_bubble_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.ex_bubble   = ex_bubble_q;
  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.muldiv_busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fwd_hazard_ctrl
// Brief  : Directed bench for fwd_hazard_ctrl with an expected-result queue.
//          Optional feature macro: WB_BYPASS_EN (sequences avoid WB-only hits).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_ctrl;
  import fwd_hazard_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  // {muldiv_busy, ex_bubble, fwd_a_sel, fwd_b_sel} expected after each edge
  logic [5:0] sb_q[$];

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl #(
    .MULDIV_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic md, input logic hl);
    bus.id_valid      = v;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rs_use     = rsu;
    bus.id_rt_use     = rtu;
    bus.id_rd         = rd;
    bus.id_wr_en      = wr;
    bus.id_is_load    = ld;
    bus.id_is_muldiv  = md;
    bus.id_reads_hilo = hl;
  endtask

  // Called just after a rising edge with ID inputs already applied.
  task automatic cycle(input string tag, input logic exp_stall, input logic exp_bub,
                       input logic [1:0] ea, input logic [1:0] eb, input logic exp_busy);
    logic [5:0] e;
    #1;
    chk({tag, ".stall"}, {3'b0, bus.stall_o}, {3'b0, exp_stall});
    sb_q.push_back({exp_busy, exp_bub, ea, eb});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".bubble"}, {3'b0, bus.ex_bubble},   {3'b0, e[4]});
    chk({tag, ".sel_a"},  {2'b0, bus.fwd_a_sel},   {2'b0, e[3:2]});
    chk({tag, ".sel_b"},  {2'b0, bus.fwd_b_sel},   {2'b0, e[1:0]});
    chk({tag, ".busy"},   {3'b0, bus.muldiv_busy}, {3'b0, e[5]});
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    for (int i = 0; i < n; i++) cycle("idle", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus.flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst.stall",  {3'b0, bus.stall_o},     4'd0);
    chk("rst.bubble", {3'b0, bus.ex_bubble},   4'd1);
    chk("rst.sel_a",  {2'b0, bus.fwd_a_sel},   4'd0);
    chk("rst.sel_b",  {2'b0, bus.fwd_b_sel},   4'd0);
    chk("rst.busy",   {3'b0, bus.muldiv_busy}, 4'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back ALU dependency: EX/MEM forward on operand A
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("add_r3", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("add_r4", 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
    idle(3);

    // Load-use: one stall, one bubble, then MEM/WB forward on both operands
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("lw_r7", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("lu_stall", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    cycle("lu_go", 1'b0, 1'b0, 2'd2, 2'd2, 1'b0);
    idle(3);

    // Register 0 never forwards nor stalls, even from a load
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("add_r0", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("lw_r0", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("rd_r0", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    idle(3);

    // EX and MEM both write r9: youngest wins; then MEM-only and unused operand
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("r9_a", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    cycle("r9_b", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("rd_r9", 1'b0, 1'b0, 2'd1, 2'd1, 1'b0);
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("mem_r9", 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
    set_id(1'b1, 5'd10, 5'd10, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("unused_rs", 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
    idle(3);

    // mult then mflo: four stall cycles while HI/LO is busy
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("mult", 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("mflo_s1", 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    cycle("mflo_s2", 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    cycle("mflo_s3", 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    cycle("mflo_s4", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    cycle("mflo_go", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    idle(3);

    // Flush wins over a load-use stall; the load still forwards from MEM next
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("lw_r7b", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    cycle("flush", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    bus.flush = 1'b0;
    cycle("post_flush", 1'b0, 1'b0, 2'd2, 2'd2, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a load-use stall
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("add_r7", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("lw_fwd", 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre_rst.stall", {3'b0, bus.stall_o}, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.stall",  {3'b0, bus.stall_o},   4'd0);
    chk("mid_rst.bubble", {3'b0, bus.ex_bubble}, 4'd1);
    chk("mid_rst.sel_a",  {2'b0, bus.fwd_a_sel}, 4'd0);
    chk("mid_rst.sel_b",  {2'b0, bus.fwd_b_sel}, 4'd0);
    #1;
    rst_n = 1'b1;
    // Pipeline is empty after release, so the consumer enters with no forward
    cycle("post_rst", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    idle(1);

    chk("sb_empty", 4'(sb_q.size()), 4'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
